// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator answering a host start pulse with a 40-bit frame
// Ports:
//   i_Clock, i_Rst_n      clock (rising edge), asynchronous active-low reset
//   i_Bus                 sampled level of the shared open-drain data wire
//   o_Bus_Low             1 = pull the wire low, 0 = release it
//   i_Hum_Int/i_Hum_Float/i_Temp_Int/i_Temp_Float  data bytes, latched when a start is accepted
//   o_Busy                high from start acceptance to the end of the frame
//   o_Done, o_Collision   one-cycle pulses on frame completion / abort
//   i_Crc_Corrupt         only with DHT11_RESP_ERR_INJ_EN defined: flips checksum bit 0
module dht11_responder #(
    parameter int CYC_PER_US   = 100,
    parameter int START_MIN_US = 5000
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Bus,
    output logic       o_Bus_Low,
    input  logic [7:0] i_Hum_Int,
    input  logic [7:0] i_Hum_Float,
    input  logic [7:0] i_Temp_Int,
    input  logic [7:0] i_Temp_Float,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Collision
`ifdef DHT11_RESP_ERR_INJ_EN
    ,
    input  logic       i_Crc_Corrupt
`endif
);
    typedef enum logic [2:0] {
        IDLE, START_LOW, RESP_DLY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;
    // Terminal counts are duration-1: a phase entered with cnt=0 lasts exactly N cycles
    localparam logic [23:0] START_M1 = 24'(START_MIN_US * CYC_PER_US - 1);
    localparam logic [23:0] T26_M1   = 24'(26 * CYC_PER_US - 1);
    localparam logic [23:0] T30_M1   = 24'(30 * CYC_PER_US - 1);
    localparam logic [23:0] T50_M1   = 24'(50 * CYC_PER_US - 1);
    localparam logic [23:0] T70_M1   = 24'(70 * CYC_PER_US - 1);
    localparam logic [23:0] T80_M1   = 24'(80 * CYC_PER_US - 1);

    state_t      state;
    logic [1:0]  sync;
    logic [23:0] cnt;
    logic [23:0] cnt_inc;
    logic [23:0] dur_m1;
    logic [5:0]  bit_idx;
    logic [39:0] frame;
    logic [7:0]  chk;
    logic        bus_s;
    logic        t_done;

    assign bus_s   = sync[1];
    assign cnt_inc = &cnt ? cnt : cnt + 24'd1;
    assign t_done  = cnt == dur_m1;

    always_comb begin
        chk = i_Hum_Int + i_Hum_Float + i_Temp_Int + i_Temp_Float;
`ifdef DHT11_RESP_ERR_INJ_EN
        chk = chk ^ {7'd0, i_Crc_Corrupt};
`endif
        dur_m1 = state == RESP_DLY                        ? T30_M1 :
                 (state == RESP_LOW || state == RESP_HIGH) ? T80_M1 :
                 (state == BIT_LOW || state == END_LOW)    ? T50_M1 :
                 frame[39]                                 ? T70_M1 : T26_M1;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= IDLE;
            sync        <= 2'b11;
            cnt         <= '0;
            bit_idx     <= '0;
            frame       <= '0;
            o_Bus_Low   <= 1'b0;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_Collision <= 1'b0;
        end else begin
            sync        <= {sync[0], i_Bus};
            o_Done      <= 1'b0;
            o_Collision <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus_s) begin
                        state <= START_LOW;
                        cnt   <= '0;
                    end
                end
                START_LOW: begin
                    if (!bus_s) begin
                        cnt <= cnt_inc;
                    end else if (cnt >= START_M1) begin
                        state   <= RESP_DLY;
                        cnt     <= '0;
                        bit_idx <= '0;
                        o_Busy  <= 1'b1;
                        frame   <= {i_Hum_Int, i_Hum_Float, i_Temp_Int, i_Temp_Float, chk};
                    end else begin
                        state <= IDLE;
                    end
                end
                RESP_DLY: begin
                    if (t_done) begin
                        state     <= RESP_LOW;
                        cnt       <= '0;
                        o_Bus_Low <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RESP_LOW, BIT_LOW: begin
                    if (t_done) begin
                        state     <= state == RESP_LOW ? RESP_HIGH : BIT_HIGH;
                        cnt       <= '0;
                        o_Bus_Low <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RESP_HIGH, BIT_HIGH: begin
                    // The first two released cycles still show our own low through the synchronizer
                    if (!bus_s && cnt >= 24'd2) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        o_Bus_Low   <= 1'b0;
                        o_Busy      <= 1'b0;
                        o_Collision <= 1'b1;
                    end else if (t_done) begin
                        cnt       <= '0;
                        o_Bus_Low <= 1'b1;
                        if (state == RESP_HIGH) begin
                            state <= BIT_LOW;
                        end else if (bit_idx == 6'd39) begin
                            state <= END_LOW;
                        end else begin
                            state   <= BIT_LOW;
                            bit_idx <= bit_idx + 6'd1;
                            frame   <= frame << 1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                END_LOW: begin
                    if (t_done) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        o_Bus_Low <= 1'b0;
                        o_Busy    <= 1'b0;
                        o_Done    <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: directed bench for dht11_responder (2 cycles/us, 100 us start threshold)
module tb_dht11_responder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_low = 1'b0;
    logic [7:0] hum_i = '0, hum_f = '0, temp_i = '0, temp_f = '0;
    wire        bus_low, busy, done, coll, bus;
    int         vectors = 0, errs = 0;
    int         n_done = 0, n_coll = 0, n_both = 0;
`ifdef DHT11_RESP_ERR_INJ_EN
    logic       crc_corrupt = 1'b0;
`endif

    assign bus = ~(bus_low | host_low);

    dht11_responder #(.CYC_PER_US(2), .START_MIN_US(100)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Bus(bus), .o_Bus_Low(bus_low),
        .i_Hum_Int(hum_i), .i_Hum_Float(hum_f), .i_Temp_Int(temp_i), .i_Temp_Float(temp_f),
        .o_Busy(busy), .o_Done(done), .o_Collision(coll)
`ifdef DHT11_RESP_ERR_INJ_EN
        , .i_Crc_Corrupt(crc_corrupt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) n_done++;
        if (coll) n_coll++;
        if (done && coll) n_both++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] want);
        vectors++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic set_data(input logic [31:0] d);
        {hum_i, hum_f, temp_i, temp_f} = d;
    endtask

    task automatic start(input int l);
        @(negedge clk) host_low = 1'b1;
        repeat (l) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Length in cycles of the current o_Bus_Low phase, bounded
    task automatic run(input logic lvl, output int n);
        n = 0;
        while (bus_low === lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic read_frame(input int coll_bit, output logic [39:0] bits, output int bad,
                              output logic busy_seen);
        int n;
        bits = '0;
        bad  = 0;
        run(1'b0, n);
        if (n != 63) bad++;
        busy_seen = busy;
        {hum_i, hum_f, temp_i, temp_f} = ~{hum_i, hum_f, temp_i, temp_f};
        run(1'b1, n);
        if (n != 160) bad++;
        run(1'b0, n);
        if (n != 160) bad++;
        for (int i = 0; i < 40; i++) begin
            run(1'b1, n);
            if (n != 100) bad++;
            if (i == coll_bit) begin
                repeat (40) @(negedge clk);
                host_low = 1'b1;
                repeat (40) @(negedge clk);
                host_low = 1'b0;
                return;
            end
            run(1'b0, n);
            if (n != 52 && n != 140) bad++;
            bits = {bits[38:0], n > 96};
        end
        run(1'b1, n);
        if (n != 100) bad++;
    endtask

    task automatic frame(input string nm, input int l, input logic [39:0] want);
        logic [39:0] bits;
        int          bad, d0;
        logic        bsy;
        d0 = n_done;
        start(l);
        read_frame(-1, bits, bad, bsy);
        check($sformatf("%s_bits", nm), bits, want);
        check($sformatf("%s_timing_errs", nm), 40'(bad), 40'd0);
        check($sformatf("%s_busy_in_frame", nm), 40'(bsy), 40'd1);
        check($sformatf("%s_done_at_release", nm), 40'(done), 40'd1);
        @(negedge clk);
        check($sformatf("%s_after", nm), 40'({done, busy, bus_low}), 40'd0);
        check($sformatf("%s_done_count", nm), 40'(n_done - d0), 40'd1);
    endtask

    initial begin
        logic [39:0] bits;
        int          bad, seen, d0, c0, n;
        logic        bsy;
        #2;
        check("reset_outputs", 40'({bus_low, busy, done, coll}), 40'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        set_data(32'h37001905);
        start(199);
        seen = 0;
        repeat (600) @(negedge clk) if (bus_low || busy) seen++;
        check("short_start_quiet", 40'(seen), 40'd0);

        set_data(32'h37001905);
        frame("basic", 200, 40'h3700190555);
        repeat (20) @(negedge clk);
        set_data(32'hFFFFFFFF);
        frame("all_ones", 360, 40'hFFFFFFFFFC);
        repeat (20) @(negedge clk);
        set_data(32'h80800101);
        frame("carry", 360, 40'h8080010102);
        repeat (20) @(negedge clk);
        set_data(32'hA53C817E);
        frame("mixed", 360, 40'hA53C817EE0);
        repeat (20) @(negedge clk);

        set_data(32'h37001905);
        d0 = n_done;
        c0 = n_coll;
        start(300);
        read_frame(10, bits, bad, bsy);
        repeat (5) @(negedge clk);
        check("coll_pulse_count", 40'(n_coll - c0), 40'd1);
        check("coll_no_done", 40'(n_done - d0), 40'd0);
        check("coll_idle", 40'({busy, bus_low}), 40'd0);
        set_data(32'h37001905);
        frame("post_coll", 300, 40'h3700190555);
        repeat (20) @(negedge clk);

        set_data(32'h37001905);
        d0 = n_done;
        start(300);
        run(1'b0, n);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_release_now", 40'({bus_low, busy}), 40'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_done", 40'(n_done - d0), 40'd0);
        set_data(32'h37001905);
        frame("post_rst", 360, 40'h3700190555);
`ifdef DHT11_RESP_ERR_INJ_EN
        repeat (20) @(negedge clk);
        set_data(32'h37001905);
        crc_corrupt = 1'b1;
        frame("crc_corrupt", 300, 40'h3700190554);
        crc_corrupt = 1'b0;
`endif
        check("done_coll_overlap", 40'(n_both), 40'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/dht11_responder.md
DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 Parameter CYC_PER_US, default 100, gives clock cycles per microsecond (100 MHz clock).
REQ-002 Parameter START_MIN_US, default 5000, is the minimum host low time in microseconds accepted as a start request.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- i_Clock, in, 1: single clock, rising edge.
- i_Rst_n, in, 1: asynchronous, active-low reset.
- i_Bus, in, 1: sampled level of the shared data wire.
- o_Bus_Low, out, 1: 1 = pull wire low; 0 = release (open-drain).
- i_Hum_Int, in, 8: humidity integer byte.
- i_Hum_Float, in, 8: humidity fractional byte.
- i_Temp_Int, in, 8: temperature integer byte.
- i_Temp_Float, in, 8: temperature fractional byte.
- o_Busy, out, 1: high from start acceptance to end of frame.
- o_Done, out, 1: one-cycle pulse on frame completion.
- o_Collision, out, 1: one-cycle pulse on abort.

Function
REQ-004 i_Bus SHALL pass through a 2-flop synchronizer; all decisions use the synchronized level (2-cycle input latency).
REQ-005 States SHALL be IDLE, START_LOW, RESP_DLY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-006 IDLE: o_Bus_Low=0; synchronized bus low -> START_LOW with the counter cleared.
REQ-007 START_LOW: bus returning high before START_MIN_US*CYC_PER_US cycles -> IDLE silently.
REQ-008 START_LOW: bus returning high at or after that threshold -> RESP_DLY, and the four data bytes are latched.
REQ-009 Checksum SHALL be the 8-bit sum of the four latched bytes, modulo 256 (carry discarded), latched at the same time.
REQ-010 RESP_DLY SHALL hold the wire released for 30 us, then go to RESP_LOW.
REQ-011 RESP_LOW SHALL drive the wire low for 80 us; RESP_HIGH SHALL release it for 80 us.
REQ-012 40 bits SHALL be sent MSB first, in this order: Hum_Int, Hum_Float, Temp_Int, Temp_Float, checksum.
REQ-013 Each bit SHALL be BIT_LOW, driving low for 50 us, then BIT_HIGH, released for 26 us for a 0 or 70 us for a 1.
REQ-014 The bit index SHALL be 6 bits, counting 0..39; after bit 39 BIT_HIGH -> END_LOW.
REQ-015 END_LOW SHALL drive low for 50 us, then release, pulse o_Done, and return to IDLE.
REQ-016 Phase durations SHALL be exact to the cycle: N us = N*CYC_PER_US cycles of o_Bus_Low at the stated level.
REQ-017 The delay counter SHALL be 24 bits and saturate; it never wraps.
REQ-018 In RESP_HIGH or BIT_HIGH, a synchronized bus low seen later than 2 cycles after release (host collision) SHALL cause o_Bus_Low=0, a one-cycle o_Collision pulse, and IDLE.
REQ-019 After an abort, the next start SHALL require a fresh full START_MIN_US low period.
REQ-020 Data input changes while o_Busy=1 SHALL NOT affect the frame in progress.
REQ-021 o_Busy SHALL be 1 from RESP_DLY entry through END_LOW exit, inclusive.
REQ-022 o_Done and o_Collision SHALL never assert in the same cycle.

Reset
REQ-023 i_Rst_n=0 SHALL immediately and asynchronously force the following values:
- state IDLE, o_Bus_Low=0, o_Busy=0, o_Done=0, o_Collision=0;
- counter 0, bit index 0, latched data 0, synchronizer flops 1.
REQ-024 Reset asserted mid-frame SHALL release the wire within the same cycle, with no o_Done pulse; operation resumes from IDLE after deassertion.

Configuration
REQ-025 Macro DHT11_RESP_ERR_INJ_EN, when defined, SHALL add input i_Crc_Corrupt (1 bit), sampled at start acceptance.
REQ-026 With the macro defined and i_Crc_Corrupt=1, the transmitted checksum SHALL be the true checksum XOR 8'h01.
REQ-027 Without the macro, i_Crc_Corrupt SHALL not exist and the checksum SHALL always be correct.

Verification
REQ-028 Bytes 0x37,0x00,0x19,0x05; host low 18 ms then release -> wire bits MSB-first 00110111 00000000 00011001 00000101 01010101 (checksum 0x55), o_Done once, o_Busy low afterwards.
REQ-029 Host low 4999 us then release -> no response, o_Bus_Low stays 0, o_Busy stays 0.
REQ-030 Bytes 0xFF,0xFF,0xFF,0xFF -> checksum 0xFC on the wire; every 1-bit high phase is exactly 7000 cycles and every low phase exactly 5000 cycles.
REQ-031 Host drives low 20 us into bit 10 high phase -> o_Collision pulse, IDLE, no o_Done; the next valid start produces a full frame.
REQ-032 i_Rst_n pulled low during RESP_LOW -> o_Bus_Low=0 in the same cycle; after release, a valid 18 ms start yields a correct frame.
REQ-033 With DHT11_RESP_ERR_INJ_EN and i_Crc_Corrupt=1 on bytes 0x37,0x00,0x19,0x05 -> transmitted checksum 0x54.
